// File: rtl/mips_alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_regfile
// Brief    : Multicycle MIPS execution core: 32x32 register file ($0 reads as
//            zero, async active-low clear) plus a 3-bit-coded combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we3,
    input  logic [$clog2(NREGS)-1:0]   ra1,
    input  logic [$clog2(NREGS)-1:0]   ra2,
    input  logic [$clog2(NREGS)-1:0]   wa3,
    input  logic [WIDTH-1:0]           wd3,
    output logic [WIDTH-1:0]           rd1,
    output logic [WIDTH-1:0]           rd2,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic [2:0]                 alucont,
    output logic [WIDTH-1:0]           result,
    output logic                       zero
);

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != '0)) begin
            regs[wa3] <= wd3;
        end
    end

    // $0 is forced to zero on read so its storage content never matters
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic             slt;

    assign sum  = A + B;
    assign diff = A - B;

    // Signed overflow on A-B: operands differ in sign and the result sign
    // differs from A; the true "less than" is the result sign flipped by it.
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    assign slt     = diff[WIDTH-1] ^ sub_ovf;

    always_comb begin
        result = '0;
        case (alucont)
            ALU_AND:  result = A & B;
            ALU_OR:   result = A | B;
            ALU_ADD:  result = sum;
            ALU_ANDN: result = A & ~B;
            ALU_ORN:  result = A | ~B;
            ALU_SUB:  result = diff;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_alu_regfile
// Brief    : Self-checking bench for mips_alu_regfile with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_alu_regfile;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [31:0] wd3;
    logic [31:0] rd1, rd2;
    logic [31:0] A, B;
    logic [2:0]  alucont;
    logic [31:0] result;
    logic        zero;

    int checks;
    int errors;

    logic [31:0] model [32];

    mips_alu_regfile #(.WIDTH(32), .NREGS(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .we3     (we3),
        .ra1     (ra1),
        .ra2     (ra2),
        .wa3     (wa3),
        .wd3     (wd3),
        .rd1     (rd1),
        .rd2     (rd2),
        .A       (A),
        .B       (B),
        .alucont (alucont),
        .result  (result),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    // Drive a write mid-cycle, let it land on the next rising edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        @(posedge clk); #1;
        if (a != 5'd0) model[a] = d;
        we3 = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 32; i++) begin
            ra1 = i[4:0]; ra2 = 5'(31 - i); #1;
            checks++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_clear r%0d: rd1=%h rd2=%h required 0", i, rd1, rd2);
            end
        end
    endtask

    task automatic test_async_reset;
        write_reg(5'd5, 32'hDEADBEEF);
        ra1 = 5'd5; #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL pre_reset_r5: rd1=%h required deadbeef", rd1);
        end
        // pull reset between edges; contents must clear without a clock edge
        #1 reset = 1'b0; #1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        checks++;
        if (rd1 !== 32'd0) begin
            errors++; $display("FAIL async_reset_r5: rd1=%h required 0", rd1);
        end
        // writes blocked while reset is low
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hCAFEF00D;
        @(posedge clk); #1;
        ra2 = 5'd7; #1;
        checks++;
        if (rd2 !== 32'd0) begin
            errors++; $display("FAIL write_during_reset: rd2=%h required 0", rd2);
        end
        we3 = 1'b0;
        #1 reset = 1'b1;
        test_reset();
        // first write after release lands on the next edge
        write_reg(5'd7, 32'h0BADF00D);
        ra2 = 5'd7; #1;
        checks++;
        if (rd2 !== 32'h0BADF00D) begin
            errors++; $display("FAIL write_after_release: rd2=%h required 0badf00d", rd2);
        end
    endtask

    task automatic test_zero_reg;
        write_reg(5'd0, 32'hFFFFFFFF);
        ra1 = 5'd0; #1;
        checks++;
        if (rd1 !== 32'd0) begin
            errors++; $display("FAIL r0_write: rd1=%h required 0", rd1);
        end
        ra2 = 5'd31;
        we3 = 1'b1; wa3 = 5'd31; wd3 = 32'h12345678; #1;
        checks++;
        if (rd2 !== model_read(5'd31)) begin
            errors++; $display("FAIL r31_before_edge: rd2=%h required %h", rd2, model_read(5'd31));
        end
        @(posedge clk); #1;
        model[31] = 32'h12345678;
        we3 = 1'b0;
        checks++;
        if (rd2 !== 32'h12345678) begin
            errors++; $display("FAIL r31_after_edge: rd2=%h required 12345678", rd2);
        end
    endtask

    task automatic test_dual_read_no_bypass;
        write_reg(5'd8, 32'd7);
        write_reg(5'd9, 32'd5);
        ra1 = 5'd8; ra2 = 5'd9; #1;
        checks++;
        if (rd1 !== 32'd7 || rd2 !== 32'd5) begin
            errors++; $display("FAIL dual_read: rd1=%h rd2=%h required 7 5", rd1, rd2);
        end
        ra2 = 5'd8; #1;
        checks++;
        if (rd1 !== 32'd7 || rd2 !== 32'd7) begin
            errors++; $display("FAIL same_addr_read: rd1=%h rd2=%h required 7 7", rd1, rd2);
        end
        we3 = 1'b1; wa3 = 5'd8; wd3 = 32'd9; #1;
        checks++;
        if (rd1 !== 32'd7) begin
            errors++; $display("FAIL no_bypass_before: rd1=%h required 7", rd1);
        end
        @(posedge clk); #1;
        model[8] = 32'd9;
        we3 = 1'b0;
        checks++;
        if (rd1 !== 32'd9) begin
            errors++; $display("FAIL no_bypass_after: rd1=%h required 9", rd1);
        end
    endtask

    task automatic test_regfile_random;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            we3 = w; wa3 = a; wd3 = d;
            ra1 = 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rd1 !== model_read(ra1) || rd2 !== model_read(ra2)) begin
                errors++;
                $display("FAIL rf_rand_pre n=%0d: rd1=%h rd2=%h required %h %h",
                         n, rd1, rd2, model_read(ra1), model_read(ra2));
            end
            @(posedge clk); #1;
            if (w && a != 5'd0) model[a] = d;
            checks++;
            if (rd1 !== model_read(ra1) || rd2 !== model_read(ra2)) begin
                errors++;
                $display("FAIL rf_rand_post n=%0d: rd1=%h rd2=%h required %h %h",
                         n, rd1, rd2, model_read(ra1), model_read(ra2));
            end
        end
        we3 = 1'b0;
    endtask

    task automatic test_alu_directed;
        logic [31:0] ta [12];
        logic [31:0] tb [12];
        logic [2:0]  tc [12];
        logic [31:0] te [12];
        ta = '{32'h0F0F00FF, 32'h0F0F00FF, 32'h0F0F00FF, 32'h0F0F00FF, 32'hFFFFFFFF,
               32'd3, 32'd3, 32'h7FFFFFFF, 32'h80000000, 32'h1234, 32'hA5A5A5A5, 32'd5};
        tb = '{32'h00FF0F0F, 32'h00FF0F0F, 32'h00FF0F0F, 32'h00FF0F0F, 32'd1,
               32'd5, 32'd5, 32'h80000000, 32'h7FFFFFFF, 32'h1234, 32'h5A5A5A5A, 32'd3};
        tc = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010,
               3'b110, 3'b111, 3'b111, 3'b111, 3'b110, 3'b011, 3'b111};
        te = '{32'h000F000F, 32'h0FFF0FFF, 32'h0F0000F0, 32'hFF0FF0FF, 32'd0,
               32'hFFFFFFFE, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 12; i++) begin
            A = ta[i]; B = tb[i]; alucont = tc[i]; #1;
            checks++;
            if (result !== te[i] || zero !== (te[i] == 32'd0)) begin
                errors++;
                $display("FAIL alu_dir%0d code=%b: result=%h zero=%b required %h %b",
                         i, tc[i], result, zero, te[i], (te[i] == 32'd0));
            end
        end
    endtask

    task automatic test_alu_random;
        logic [31:0] edges [6];
        logic [31:0] exp;
        edges = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};
        for (int n = 0; n < 400; n++) begin
            A = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            B = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) B = A;
            alucont = 3'($urandom_range(0, 7));
            #1;
            exp = alu_ref(A, B, alucont);
            checks++;
            if (result !== exp || zero !== (exp == 32'd0)) begin
                errors++;
                $display("FAIL alu_rand n=%0d A=%h B=%h code=%b: result=%h zero=%b required %h %b",
                         n, A, B, alucont, result, zero, exp, (exp == 32'd0));
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
        A = '0; B = '0; alucont = '0;
        #12;
        test_reset();
        reset = 1'b1;
        #1;
        test_async_reset();
        test_zero_reg();
        test_dual_read_no_bypass();
        test_regfile_random();
        test_alu_directed();
        test_alu_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_alu_regfile.md
# mips_alu_regfile

Combined execution core for the multicycle MIPS datapath: a 32×32-bit register file (two combinational read ports, one synchronous write port, $0 hardwired to zero) and a 32-bit combinational ALU with a 3-bit control code and zero flag. The two halves are independent. The surrounding datapath latches the read data, muxes the ALU operands (PC / register / immediate / constant 4) and stores the ALU result externally.

## Interface
Parameters:
- WIDTH, 32, data width of registers and ALU
- NREGS, 32, number of registers (address width log2(NREGS) = 5)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0); clears all registers
- we3  input  1  register write enable
- ra1  input  5  read address port 1 (instr[25:21])
- ra2  input  5  read address port 2 (instr[20:16])
- wa3  input  5  write address
- wd3  input  32  write data
- rd1  output  32  read data port 1 (combinational)
- rd2  output  32  read data port 2 (combinational)
- A  input  32  ALU operand A
- B  input  32  ALU operand B
- alucont  input  3  ALU operation select
- result  output  32  ALU result (combinational)
- zero  output  1  1 when result == 0

## Operation
Register file:
- rdN = reg[raN]; when raN == 0, rdN = 0 regardless of storage.
- On rising clk with reset high and we3 = 1: reg[wa3] <= wd3. Writes to address 0 are ignored; $0 always reads 0.
- No write-through bypass: a read of the address being written returns the old value until the edge, then the new value.
- Both read ports may address the same register; both return the same value.

ALU (purely combinational, all arithmetic modulo 2^32):
- 000: A & B
- 001: A | B
- 010: A + B (carry discarded)
- 110: A − B (two's complement, borrow discarded)
- 111: SLT: result = 1 if signed(A) < signed(B), else 0. Computed from the sign of A − B corrected for overflow, so 0x80000000 < 0x7FFFFFFF gives 1.
- 100: A & ~B
- 101: A | ~B
- 011: reserved; result = 0 (zero = 1)
- zero = (result == 0) for every code, including reserved.
- No overflow flag and no exceptions.

## Timing
- Reset (reset = 0, asynchronous): every register cleared to 0 immediately, without waiting for a clock edge. Writes are blocked for the whole time reset is low. rd1/rd2 reflect cleared contents combinationally. ALU outputs are unaffected by reset.
- Reset deasserted mid-cycle: the first write takes effect at the next rising edge with reset high.
- Write latency 1 cycle: data presented with we3 before edge N is readable immediately after edge N.
- Read latency 0: rd1/rd2 follow ra1/ra2 and register contents combinationally.
- ALU latency 0: result/zero settle combinationally from A, B, alucont; no internal registers.
- we3 = 0: register contents hold indefinitely.

## Test plan
- Reset: write 0xDEADBEEF to r5, pull reset low between edges → rd1 (ra1 = 5) reads 0 before next edge; after release, all 32 registers read 0.
- $0 protection: we3 = 1, wa3 = 0, wd3 = 0xFFFFFFFF, clock → rd1 (ra1 = 0) = 0; write 0x12345678 to r31 → rd2 (ra2 = 31) = 0x12345678 after the edge, old value before it.
- Dual read / no bypass: r8 = 7, r9 = 5; ra1 = 8, ra2 = 9 → rd1 = 7, rd2 = 5. Write 9 to r8 and sample before the edge → rd1 = 7; after the edge → rd1 = 9.
- ALU logic and add: A = 0x0F0F00FF, B = 0x00FF0F0F → 000 gives 0x000F000F; 001 gives 0x0FFF0FFF; 100 gives 0x0F0000F0; 101 gives 0xFF0FF0FF. A = 0xFFFFFFFF, B = 1, code 010 → result 0, zero = 1.
- Sub/SLT: A = 3, B = 5: 110 gives 0xFFFFFFFE, zero = 0; 111 gives 1. A = 0x7FFFFFFF, B = 0x80000000: 111 gives 0. A = 0x80000000, B = 0x7FFFFFFF: 111 gives 1. A = B = 0x1234: 110 gives 0, zero = 1.
- Reserved code: alucont = 011 with any A, B → result 0, zero = 1.
